// File: rtl/seg_pkg.sv
// Shared encodings for the seven-segment scroll controller: FSM states,
// blank pattern, digit-enable table and a few common active-low glyphs.
package seg_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SCROLL = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry p enables AN(7-p), active low: slot 0 is the leftmost digit.
  localparam logic [7:0][7:0] DIGIT_SEL = {
    8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F
  };

  localparam logic [7:0] GLYPH_0 = 8'h03;
  localparam logic [7:0] GLYPH_H = 8'h91;
  localparam logic [7:0] GLYPH_E = 8'h61;
  localparam logic [7:0] GLYPH_L = 8'hE3;

endpackage

// File: rtl/seg_scan_timer.sv
// Digit scan prescaler: every SCAN_DIV clocks the digit slot index p
// advances 0..7 and wraps, independent of the controller state.
module seg_scan_timer #(
  parameter int SCAN_DIV = 262144
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] p_o
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    p_q, p_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    p_d   = wrap ? p_q + 3'd1 : p_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Message buffer, load/hold/scroll FSM and registered digit/segment drive
// for an 8-digit multiplexed seven-segment display.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV   = 262144,
  parameter int SCROLL_DIV = 33554432,
  parameter int MSG_MAX    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [7:0]                     wr_data,
  input  logic                           wr_last,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           clr,
  input  logic                           dir,
  output logic [7:0]                     choose,
  output logic [7:0]                     led,
  output logic [1:0]                     state_o,
  output logic [$clog2(MSG_MAX+1)-1:0]   msg_len_o
);

  localparam int LW = $clog2(MSG_MAX + 1);
  localparam int AW = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
  localparam int IW = 6;  // holds offset + p up to 39 + 7
  localparam int DW = $clog2(SCROLL_DIV);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] offset_q, offset_d;
  logic [DW-1:0] scroll_cnt_q, scroll_cnt_d;
  logic [7:0]    buf_q [2**AW];
  logic [7:0]    buf_d [2**AW];
  logic [7:0]    choose_q, choose_d;
  logic [7:0]    led_q, led_d;
  logic [2:0]    p;
  logic [IW-1:0] virt_len;
  logic [IW-1:0] idx;
  logic          wr_en;

  function automatic logic [IW-1:0] next_offset(input logic [IW-1:0] off,
                                                input logic [IW-1:0] l,
                                                input logic          right);
    if (right) return (off == '0) ? l - IW'(1) : off - IW'(1);
    else       return (off == l - IW'(1)) ? '0 : off + IW'(1);
  endfunction

  seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk (clk),
    .rst (rst),
    .p_o (p)
  );

  assign wr_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign wr_en    = wr_valid && wr_ready;
  assign virt_len = IW'(len_q) + IW'(8);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    len_d        = len_q;
    offset_d     = offset_q;
    scroll_cnt_d = scroll_cnt_q;
    buf_d        = buf_q;
    if (wr_en) buf_d[wr_ptr_q[AW-1:0]] = wr_data;
    if (clr) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      len_d        = '0;
      offset_d     = '0;
      scroll_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (wr_en) begin
            wr_ptr_d = wr_ptr_q + LW'(1);
            if (wr_last || (wr_ptr_q == LW'(MSG_MAX - 1))) begin
              len_d    = wr_ptr_q + LW'(1);
              offset_d = '0;
              state_d  = ST_HOLD;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (start && !pause) begin
            state_d      = ST_SCROLL;
            scroll_cnt_d = '0;
          end
        end
        default: begin
          // Pause takes priority over a coincident scroll tick.
          if (pause) begin
            state_d = ST_HOLD;
          end else if (scroll_cnt_q == DW'(SCROLL_DIV - 1)) begin
            scroll_cnt_d = '0;
            offset_d     = next_offset(offset_q, virt_len, dir);
          end else begin
            scroll_cnt_d = scroll_cnt_q + DW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    idx = offset_q + IW'(p);
    if (idx >= virt_len) idx = idx - virt_len;
    choose_d = DIGIT_SEL[p];
    led_d    = SEG_BLANK;
    if (((state_q == ST_SCROLL) || (state_q == ST_HOLD)) && (idx < IW'(len_q)))
      led_d = buf_q[idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      len_q        <= '0;
      offset_q     <= '0;
      scroll_cnt_q <= '0;
      choose_q     <= SEG_BLANK;
      led_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      len_q        <= len_d;
      offset_q     <= offset_d;
      scroll_cnt_q <= scroll_cnt_d;
      choose_q     <= choose_d;
      led_q        <= led_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign choose    = choose_q;
  assign led       = led_q;
  assign state_o   = state_q;
  assign msg_len_o = len_q;

endmodule
